// File: rtl/rom_pkg.sv
// Shared constants and state encoding for the lookup-ROM scan sequencer.
//   ROM_ADDR_W / ROM_DATA_W / ROM_DEPTH : geometry of the 8x4 lookup ROM
//   SUM_W                               : accumulator width (8 * 15 = 120 fits)
//   COUNT_W                             : width of the requested entry count
//   state_t, S_IDLE / S_READ / S_DONE    : sequencer states
package rom_pkg;

  localparam int unsigned ROM_ADDR_W = 3;
  localparam int unsigned ROM_DATA_W = 4;
  localparam int unsigned ROM_DEPTH  = 8;
  localparam int unsigned SUM_W      = 8;
  localparam int unsigned COUNT_W    = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_READ = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/rom_scan_ctrl_if.sv
// Control, result and ROM-bus signals of the scan sequencer.
//   slave  : the sequencer (takes start/base_addr/count/rom_data, drives the rest)
//   master : the user / ROM side
interface rom_scan_ctrl_if
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W,
  parameter int unsigned SUM_W  = rom_pkg::SUM_W
) ();

  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [COUNT_W-1:0]  count;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data;
  logic                busy;
  logic                done;
  logic [SUM_W-1:0]    sum;
  logic [DATA_W-1:0]   max_val;
  logic [ADDR_W-1:0]   max_addr;

  modport slave (
    input  start, base_addr, count, rom_data,
    output rom_addr, busy, done, sum, max_val, max_addr
  );

  modport master (
    output start, base_addr, count, rom_data,
    input  rom_addr, busy, done, sum, max_val, max_addr
  );

endinterface

// File: rtl/rom_scan_ctrl.sv
// Walks a wrap-around window of the lookup ROM and reduces it to sum, max value
// and the address of the first occurrence of that max.
//   clk : system clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : slave side of rom_scan_ctrl_if (start/base_addr/count in, rom_addr out,
//         rom_data in, busy/done/sum/max_val/max_addr out)
module rom_scan_ctrl
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W,
  parameter int unsigned SUM_W  = rom_pkg::SUM_W
) (
  input  logic            clk,
  input  logic            rst,
  rom_scan_ctrl_if.slave  bus
);

  // Longest useful window: one pass over the whole ROM.
  localparam logic [COUNT_W-1:0] MaxCount = COUNT_W'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   max_val_q, max_val_d;
  logic [ADDR_W-1:0]   max_addr_q, max_addr_d;
  logic                first_q, first_d;
  logic [COUNT_W-1:0]  clamped;

  assign clamped = (bus.count > MaxCount) ? MaxCount : bus.count;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    max_val_d   = max_val_q;
    max_addr_d  = max_addr_q;
    first_d     = first_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remaining_d = clamped;
          sum_d       = '0;
          max_val_d   = '0;
          max_addr_d  = '0;
          first_d     = 1'b1;
          state_d     = (clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        sum_d = sum_q + SUM_W'(bus.rom_data);
        // First read always loads so max_addr points inside the window even if
        // every word is zero; strict compare keeps the earliest tied address.
        if (first_q || (bus.rom_data > max_val_q)) begin
          max_val_d  = bus.rom_data;
          max_addr_d = addr_q;
        end
        first_d     = 1'b0;
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - COUNT_W'(1);
        if (remaining_q == COUNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      max_val_q   <= '0;
      max_addr_q  <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      max_val_q   <= max_val_d;
      max_addr_q  <= max_addr_d;
      first_q     <= first_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.max_val  = max_val_q;
  assign bus.max_addr = max_addr_q;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Self-checking bench for rom_scan_ctrl with an asynchronous-read ROM image.
module tb_rom_scan_ctrl;
  import rom_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [3:0] rom_img [0:7];

  rom_scan_ctrl_if bus ();

  assign bus.rom_data = rom_img[bus.rom_addr];

  rom_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fixed_image();
    rom_img[0] = 4'h3; rom_img[1] = 4'hA; rom_img[2] = 4'h0; rom_img[3] = 4'hF;
    rom_img[4] = 4'h7; rom_img[5] = 4'hF; rom_img[6] = 4'h2; rom_img[7] = 4'h5;
  endtask

  // Reference: window = the first min(cnt,8) addresses from base, wrapping mod 8.
  // Max taken over the window; its address is the earliest window position holding it.
  function automatic void model(input int base, input int cnt, output int n,
                                output int esum, output int emax, output int eaddr);
    n     = (cnt > 8) ? 8 : cnt;
    esum  = 0;
    emax  = 0;
    eaddr = 0;
    for (int i = 0; i < n; i++) begin
      esum += int'(rom_img[(base + i) % 8]);
      if (int'(rom_img[(base + i) % 8]) > emax) emax = int'(rom_img[(base + i) % 8]);
    end
    for (int i = n - 1; i >= 0; i--) begin
      if (int'(rom_img[(base + i) % 8]) == emax) eaddr = (base + i) % 8;
    end
  endfunction

  // One scan from a single start pulse; optional extra start pulse during READ cycle restart_k.
  task automatic run_scan(input int base, input int cnt, input int restart_k, input string tag);
    int n, esum, emax, eaddr, lat, amis;
    int addrs[$];
    model(base, cnt, n, esum, emax, eaddr);
    bus.start     = 1'b1;
    bus.base_addr = 3'(base);
    bus.count     = 4'(cnt);
    step();
    bus.start     = 1'b0;
    bus.base_addr = 3'($urandom);
    bus.count     = 4'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy_in_read k=%0d got=%b want=1", tag, k, bus.busy);
      end
      addrs.push_back(int'(bus.rom_addr));
      bus.start = (k == restart_k);
      step();
    end
    bus.start = 1'b0;
    total++;
    if (lat != n + 1) begin
      bad++;
      $display("FAIL %s done_latency got=%0d want=%0d (0 = no done)", tag, lat, n + 1);
    end
    amis = 0;
    foreach (addrs[i]) if (addrs[i] != (base + i) % 8) amis++;
    total++;
    if (addrs.size() != n || amis != 0) begin
      bad++;
      $display("FAIL %s rom_addr_seq got_len=%0d want_len=%0d wrong=%0d", tag, addrs.size(),
               n, amis);
    end
    total++;
    if (bus.busy !== 1'b1 || int'(bus.sum) != esum || int'(bus.max_val) != emax ||
        int'(bus.max_addr) != eaddr) begin
      bad++;
      $display("FAIL %s results busy=%b sum=%0d max=%0d addr=%0d want 1/%0d/%0d/%0d", tag,
               bus.busy, bus.sum, bus.max_val, bus.max_addr, esum, emax, eaddr);
    end
    step();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.rom_addr) != (base + n) % 8 ||
        int'(bus.sum) != esum || int'(bus.max_val) != emax || int'(bus.max_addr) != eaddr) begin
      bad++;
      $display("FAIL %s after_done done=%b busy=%b rom_addr=%0d sum=%0d max=%0d addr=%0d want 0/0/%0d/%0d/%0d/%0d",
               tag, bus.done, bus.busy, bus.rom_addr, bus.sum, bus.max_val, bus.max_addr,
               (base + n) % 8, esum, emax, eaddr);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.base_addr = 3'd5;
    bus.count = 4'd3;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 3'd0 || bus.sum !== 8'd0 ||
        bus.max_val !== 4'd0 || bus.max_addr !== 3'd0) begin
      bad++;
      $display("FAIL reset_state busy=%b done=%b rom_addr=%0d sum=%0d max=%0d addr=%0d want all 0",
               bus.busy, bus.done, bus.rom_addr, bus.sum, bus.max_val, bus.max_addr);
    end
    step();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_hold busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_full_scan();
    run_scan(0, 8, -1, "full_scan");
  endtask

  task automatic test_wrap();
    run_scan(6, 4, -1, "wrap");
  endtask

  task automatic test_zero_count();
    run_scan(4, 0, -1, "zero_count");
  endtask

  task automatic test_clamp_restart();
    run_scan(2, 12, 3, "clamp_restart");
  endtask

  task automatic test_reset_mid_scan();
    int done_seen;
    bus.start = 1'b1;
    bus.base_addr = 3'd0;
    bus.count = 4'd8;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 3'd0 || bus.sum !== 8'd0 ||
        bus.max_val !== 4'd0 || bus.max_addr !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset_state busy=%b done=%b rom_addr=%0d sum=%0d max=%0d addr=%0d want all 0",
               bus.busy, bus.done, bus.rom_addr, bus.sum, bus.max_val, bus.max_addr);
    end
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      step();
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL mid_reset_quiet active_cycles got=%0d want=0", done_seen);
    end
    run_scan(5, 1, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n, esum, emax, eaddr, lat;
    model(1, 3, n, esum, emax, eaddr);
    bus.start = 1'b1;
    bus.base_addr = 3'd1;
    bus.count = 4'd3;
    step();
    for (int rep = 0; rep < 3; rep++) begin
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        if (bus.done === 1'b1) begin
          lat = k;
          break;
        end
        step();
      end
      total++;
      if (lat != n + 1 || int'(bus.sum) != esum || int'(bus.max_val) != emax ||
          int'(bus.max_addr) != eaddr) begin
        bad++;
        $display("FAIL b2b_rep%0d lat=%0d sum=%0d max=%0d addr=%0d want %0d/%0d/%0d/%0d", rep,
                 lat, bus.sum, bus.max_val, bus.max_addr, n + 1, esum, emax, eaddr);
      end
      step();
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle_gap rep%0d busy=%b done=%b want 0/0", rep, bus.busy, bus.done);
      end
      if (rep == 2) bus.start = 1'b0;
      step();
      total++;
      if (bus.busy !== (rep < 2)) begin
        bad++;
        $display("FAIL b2b_reaccept rep%0d busy got=%b want=%b", rep, bus.busy, rep < 2);
      end
    end
    step();
  endtask

  task automatic test_random();
    int base, cnt, rk;
    for (int a = 0; a < 8; a++) rom_img[a] = 4'($urandom);
    for (int t = 0; t < 12; t++) begin
      base = int'($urandom_range(7, 0));
      cnt  = int'($urandom_range(15, 0));
      rk   = int'($urandom_range(8, 0));
      run_scan(base, cnt, (rk == 0) ? -1 : rk, $sformatf("rand%0d", t));
      if ($urandom_range(1, 0) == 1) step();
    end
    load_fixed_image();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    load_fixed_image();
    test_reset();
    test_full_scan();
    test_wrap();
    test_zero_count();
    test_clamp_restart();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_scan_ctrl.md
Name: rom_scan_ctrl

Overview:
- Sequencer that walks a window of the 8x4 lookup ROM and reduces it. On one start pulse it reads `count` consecutive entries from `base_addr`, with wrap-around.
- Produces the sum, the maximum value, and the address of that maximum.
- Sits between user control (switch/button logic) and the asynchronous-read ROM. It owns the ROM address bus and samples ROM data in the same cycle.

Parameters:
- ADDR_W, 3, ROM address width (depth = 2**ADDR_W = 8)
- DATA_W, 4, ROM word width
- SUM_W, 8, accumulator width (holds 8*15 = 120 without overflow)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a scan; level-sampled, only accepted in IDLE
- base_addr  input  ADDR_W  first ROM address of the window; sampled on accept
- count  input  4  number of entries to read; sampled on accept
- rom_addr  output  ADDR_W  registered address to ROM
- rom_data  input  DATA_W  combinational ROM read data for rom_addr
- busy  output  1  high from cycle after accept until the cycle done is high, inclusive
- done  output  1  one-cycle pulse when results are final
- sum  output  SUM_W  sum of scanned words
- max_val  output  DATA_W  largest scanned word
- max_addr  output  ADDR_W  address of first occurrence of max_val

Behaviour:
- Reset (rst=1 at edge): state IDLE.
  - rom_addr, sum, max_val, max_addr = 0; busy = 0; done = 0.
  - Reset wins over every other event, including mid-scan. Partial results are discarded.
- States: IDLE, READ, DONE. Encoding is free.
- IDLE, start=1:
  - Latch rom_addr <= base_addr.
  - remaining <= min(count, 8). Values 9..15 clamp to 8, so no address is read twice.
  - Clear sum, max_val and max_addr to 0.
  - If clamped count = 0, go to DONE; otherwise go to READ.
- IDLE, start=0: hold state. Results from the last scan remain on the outputs.
- READ, every cycle:
  - sum <= sum + zero-extended rom_data.
  - If rom_data > max_val, or this is the first read of the scan: max_val <= rom_data, max_addr <= rom_addr. Comparison is strict, so ties keep the earlier address.
  - rom_addr <= rom_addr + 1 modulo 8 (address 7 wraps to 0).
  - remaining <= remaining - 1. When remaining = 1, go to DONE.
- DONE: done = 1 for exactly this cycle, busy = 1, then return to IDLE.
- Latency:
  - Start is accepted at edge E.
  - READ occupies edges E+1 .. E+count.
  - done is high during the cycle following edge E+count (count=0: the cycle after E).
- start while busy (READ or DONE) is ignored, with no queuing. start held high continuously re-triggers a new scan in the first IDLE cycle after DONE.
- base_addr and count changing during a scan have no effect.
- rom_addr after a scan rests at base_addr + count mod 8.
- Outputs sum, max_val and max_addr are valid while done=1 and stay stable until the next accepted start.

Decomposition:
- Shared package rom_pkg holds:
  - ROM_ADDR_W = 3, ROM_DATA_W = 4, ROM_DEPTH = 8;
  - the state enum (S_IDLE, S_READ, S_DONE);
  - the SUM_W constant.
- Single module; no sub-module needed. The ROM is instantiated alongside by the top level, not inside this block.
- The bench instantiates both this block and the ROM, loading a test image.

Test Plan:
ROM image for all tests, addresses 0..7 = 3, A, 0, F, 7, F, 2, 5.
- Full scan: base=0, count=8, one-cycle start.
  - done pulses 9 cycles after accept.
  - sum = 57 (0x39), max_val = F, max_addr = 3 (tie at 5 rejected).
  - busy is high for 9 cycles.
- Wrap window: base=6, count=4.
  - rom_addr sequence is 6, 7, 0, 1.
  - sum = 20, max_val = A, max_addr = 1, final rom_addr = 2.
- Zero count: base=4, count=0.
  - done high in the cycle after accept.
  - sum = 0, max_val = 0, max_addr = 0; no READ cycles.
- Clamp plus ignored restart: base=2, count=12.
  - Clamped to 8: sum = 57, max_addr = 3.
  - A second start pulse at cycle 3 of READ is ignored: still exactly one done pulse and the same results.
- Reset mid-scan: base=0, count=8, rst asserted for 1 cycle at the 4th READ cycle.
  - Next cycle: IDLE, all outputs 0, no done pulse.
  - A new scan with base=5, count=1 then gives sum = F, max_addr = 5.
- Back-to-back: start held high.
  - A new scan is accepted in the first IDLE cycle after each done.
  - Results are identical on each done pulse.
